daq_sweep_scheduler: RTL and testbench

Sequences repeated single acquisitions of the slave DAQ controller across a threshold-DAC sweep for S-curve measurement. For each DAC value it requests a slow-control reload, arms the slave DAQ with ModuleStart, fires a programmed number of AcqStart triggers, and waits for each acquisition's OnceEnd before moving on. It sits between the USB command/register block and the slave DAQ controller, and handshakes with the slow-control loader for DAC updates.

---
 rtl/daq_sweep_scheduler_if.sv | 64 ++++++
 rtl/daq_sweep_scheduler.sv | 219 +++++++++++++++++++++
 tb/tb_daq_sweep_scheduler.sv | 345 ++++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/daq_sweep_scheduler_if.sv
// ---------------------------------------------------------------------------
// daq_sweep_scheduler_if
//
// Purpose: bundles the signals between the DAC-sweep scheduler, the USB
// command/register block, the slow-control loader and the slave DAQ
// controller.
//
// Signals (directions from the scheduler's point of view, modport master):
//   SweepStart      in   level; high runs the sweep, low aborts it
//   StartDac        in   first DAC code
//   EndDac          in   last DAC code (inclusive)
//   DacStep         in   DAC increment (0 behaves as 1)
//   TriggersPerStep in   acquisitions per DAC code (0 behaves as 1)
//   TriggerPeriod   in   idle cycles after OnceEnd before the next trigger
//   ConfigDone      in   one-cycle pulse: DAC load finished
//   OnceEnd         in   rising edge: one acquisition finished
//   ModuleStart     out  arms the slave DAQ
//   AcqStart        out  trigger to the slave DAQ
//   DacValue        out  current DAC code
//   ConfigLoad      out  one-cycle reload request to slow control
//   StepTrigCount   out  triggers completed at the current DAC code
//   Busy            out  high whenever the scheduler is not idle
//   SweepDone       out  high while the sweep has finished
//   TimeoutFlag     out  sticky OnceEnd timeout indication
//   dbg_state       out  current scheduler state encoding
//
// Handshake: ConfigLoad is a one-cycle request; the loader answers with a
// one-cycle ConfigDone once the DAC holds DacValue. Only the ConfigDone that
// arrives while the scheduler is waiting for it is honoured; any other pulse
// is dropped. The request is never repeated while outstanding.
// ---------------------------------------------------------------------------
interface daq_sweep_scheduler_if;
    logic        SweepStart;
    logic [9:0]  StartDac;
    logic [9:0]  EndDac;
    logic [9:0]  DacStep;
    logic [15:0] TriggersPerStep;
    logic [15:0] TriggerPeriod;
    logic        ConfigDone;
    logic        OnceEnd;
    logic        ModuleStart;
    logic        AcqStart;
    logic [9:0]  DacValue;
    logic        ConfigLoad;
    logic [15:0] StepTrigCount;
    logic        Busy;
    logic        SweepDone;
    logic        TimeoutFlag;
    logic [3:0]  dbg_state;

    modport master (
        input  SweepStart, StartDac, EndDac, DacStep, TriggersPerStep,
               TriggerPeriod, ConfigDone, OnceEnd,
        output ModuleStart, AcqStart, DacValue, ConfigLoad, StepTrigCount,
               Busy, SweepDone, TimeoutFlag, dbg_state
    );

    modport slave (
        output SweepStart, StartDac, EndDac, DacStep, TriggersPerStep,
               TriggerPeriod, ConfigDone, OnceEnd,
        input  ModuleStart, AcqStart, DacValue, ConfigLoad, StepTrigCount,
               Busy, SweepDone, TimeoutFlag, dbg_state
    );
endinterface

// File: rtl/daq_sweep_scheduler.sv
// ---------------------------------------------------------------------------
// daq_sweep_scheduler
//
// Purpose: walks the threshold DAC from StartDac to EndDac for S-curve
// measurement. For each code it requests a slow-control reload, arms the
// slave DAQ (ModuleStart), fires TriggersPerStep AcqStart pulses and waits
// for each acquisition's OnceEnd (with timeout) before moving on.
//
// Ports:
//   Clk    system clock
//   reset  synchronous, active-high reset
//   bus    daq_sweep_scheduler_if.master (see the interface header)
//
// Parameters:
//   ARM_WAIT     cycles from ModuleStart rise to the first trigger (>= 1)
//   TRIG_WIDTH   AcqStart high time in cycles (>= 1)
//   DROP_CYCLES  ModuleStart low time between DAC steps
//   TIMEOUT      maximum cycles to wait for OnceEnd per trigger (>= 1)
// ---------------------------------------------------------------------------
module daq_sweep_scheduler #(
    parameter int unsigned ARM_WAIT    = 64,
    parameter int unsigned TRIG_WIDTH  = 4,
    parameter int unsigned DROP_CYCLES = 16,
    parameter int unsigned TIMEOUT     = 65535
) (
    input logic                   Clk,
    input logic                   reset,
    daq_sweep_scheduler_if.master bus
);

    typedef enum logic [3:0] {
        S_IDLE     = 4'd0,
        S_LOAD     = 4'd1,
        S_WAIT_CFG = 4'd2,
        S_ARM      = 4'd3,
        S_TRIG     = 4'd4,
        S_WAIT_END = 4'd5,
        S_GAP      = 4'd6,
        S_NEXT     = 4'd7,
        S_DONE     = 4'd8
    } state_t;

    // One shared delay counter; 17 bits so a full 16-bit TIMEOUT or
    // TriggerPeriod never wraps.
    localparam int CW = 17;
    localparam logic [CW-1:0] ONE        = CW'(1);
    localparam logic [CW-1:0] ARM_LAST   = CW'(ARM_WAIT - 1);
    localparam logic [CW-1:0] TRIG_LAST  = CW'(TRIG_WIDTH - 1);
    localparam logic [CW-1:0] TOUT_LAST  = CW'(TIMEOUT - 1);
    // NEXT lasts DROP_CYCLES+1 cycles so that ModuleStart stays low for at
    // least DROP_CYCLES+1 cycles before the (registered) ConfigLoad rises.
    localparam logic [CW-1:0] DROP_LAST  = CW'(DROP_CYCLES);

    state_t        state_q;
    logic [CW-1:0] cnt_q;
    logic [9:0]    dac_q;
    logic [15:0]   step_cnt_q;
    logic          module_start_q;
    logic          acq_start_q;
    logic          config_load_q;
    logic          busy_q;
    logic          sweep_done_q;
    logic          timeout_q;
    logic          once_end_r_q;
    logic          once_end_rr_q;

    logic          once_end_edge;
    logic [15:0]   eff_tps;
    logic [9:0]    eff_step;
    logic [10:0]   next_dac;
    logic          dac_overrun;
    logic          abort;

    assign once_end_edge = once_end_r_q & ~once_end_rr_q;
    assign eff_tps       = (bus.TriggersPerStep == 16'd0) ? 16'd1 : bus.TriggersPerStep;
    assign eff_step      = (bus.DacStep == 10'd0) ? 10'd1 : bus.DacStep;
    // Computed in 11 bits so a step past 1023 is seen as overrun, not a wrap.
    assign next_dac      = {1'b0, dac_q} + {1'b0, eff_step};
    assign dac_overrun   = (next_dac > {1'b0, bus.EndDac}) || next_dac[10];
    assign abort         = !bus.SweepStart && (state_q != S_IDLE) && (state_q != S_DONE);

    always_ff @(posedge Clk) begin
        if (reset) begin
            state_q        <= S_IDLE;
            cnt_q          <= '0;
            dac_q          <= '0;
            step_cnt_q     <= '0;
            module_start_q <= 1'b0;
            acq_start_q    <= 1'b0;
            config_load_q  <= 1'b0;
            busy_q         <= 1'b0;
            sweep_done_q   <= 1'b0;
            timeout_q      <= 1'b0;
            once_end_r_q   <= 1'b0;
            once_end_rr_q  <= 1'b0;
        end else begin
            once_end_r_q  <= bus.OnceEnd;
            once_end_rr_q <= once_end_r_q;

            // Strobe outputs follow the state one cycle later.
            module_start_q <= (state_q == S_ARM) || (state_q == S_TRIG) ||
                              (state_q == S_WAIT_END) || (state_q == S_GAP);
            acq_start_q    <= (state_q == S_TRIG);
            config_load_q  <= (state_q == S_LOAD);

            if (abort) begin
                // DacValue, StepTrigCount and TimeoutFlag keep their values.
                state_q        <= S_IDLE;
                cnt_q          <= '0;
                module_start_q <= 1'b0;
                acq_start_q    <= 1'b0;
                config_load_q  <= 1'b0;
                busy_q         <= 1'b0;
            end else begin
                unique case (state_q)
                    S_IDLE: begin
                        if (bus.SweepStart) begin
                            state_q    <= S_LOAD;
                            dac_q      <= bus.StartDac;
                            timeout_q  <= 1'b0;
                            step_cnt_q <= '0;
                            busy_q     <= 1'b1;
                        end
                    end
                    S_LOAD: begin
                        state_q <= S_WAIT_CFG;
                    end
                    S_WAIT_CFG: begin
                        if (bus.ConfigDone) begin
                            state_q <= S_ARM;
                            cnt_q   <= '0;
                        end
                    end
                    S_ARM: begin
                        if (cnt_q == ARM_LAST) begin
                            state_q <= S_TRIG;
                            cnt_q   <= '0;
                        end else begin
                            cnt_q <= cnt_q + ONE;
                        end
                    end
                    S_TRIG: begin
                        if (cnt_q == TRIG_LAST) begin
                            state_q <= S_WAIT_END;
                            cnt_q   <= '0;
                        end else begin
                            cnt_q <= cnt_q + ONE;
                        end
                    end
                    S_WAIT_END: begin
                        // The edge is tested first so it wins over a
                        // coincident timeout.
                        if (once_end_edge) begin
                            state_q    <= S_GAP;
                            step_cnt_q <= step_cnt_q + 16'd1;
                            cnt_q      <= '0;
                        end else if (cnt_q == TOUT_LAST) begin
                            state_q    <= S_GAP;
                            timeout_q  <= 1'b1;
                            step_cnt_q <= step_cnt_q + 16'd1;
                            cnt_q      <= '0;
                        end else begin
                            cnt_q <= cnt_q + ONE;
                        end
                    end
                    S_GAP: begin
                        // A TriggerPeriod of 0 still spends one cycle here.
                        if ((cnt_q + ONE) >= {1'b0, bus.TriggerPeriod}) begin
                            cnt_q <= '0;
                            if (step_cnt_q < eff_tps) begin
                                state_q <= S_TRIG;
                            end else begin
                                state_q <= S_NEXT;
                            end
                        end else begin
                            cnt_q <= cnt_q + ONE;
                        end
                    end
                    S_NEXT: begin
                        if (dac_overrun) begin
                            state_q      <= S_DONE;
                            sweep_done_q <= 1'b1;
                        end else if (cnt_q == DROP_LAST) begin
                            state_q    <= S_LOAD;
                            dac_q      <= next_dac[9:0];
                            step_cnt_q <= '0;
                            cnt_q      <= '0;
                        end else begin
                            cnt_q <= cnt_q + ONE;
                        end
                    end
                    S_DONE: begin
                        if (!bus.SweepStart) begin
                            state_q      <= S_IDLE;
                            sweep_done_q <= 1'b0;
                            busy_q       <= 1'b0;
                        end
                    end
                    default: begin
                        state_q      <= S_IDLE;
                        busy_q       <= 1'b0;
                        sweep_done_q <= 1'b0;
                    end
                endcase
            end
        end
    end

    assign bus.ModuleStart   = module_start_q;
    assign bus.AcqStart      = acq_start_q;
    assign bus.DacValue      = dac_q;
    assign bus.ConfigLoad    = config_load_q;
    assign bus.StepTrigCount = step_cnt_q;
    assign bus.Busy          = busy_q;
    assign bus.SweepDone     = sweep_done_q;
    assign bus.TimeoutFlag   = timeout_q;
    assign bus.dbg_state     = state_q;

endmodule

// File: tb/tb_daq_sweep_scheduler.sv
// ---------------------------------------------------------------------------
// tb_daq_sweep_scheduler
//
// Directed bench for daq_sweep_scheduler. A background process models the
// slow-control loader (ConfigDone a few cycles after ConfigLoad) and the
// slave DAQ (OnceEnd about 20 cycles after each AcqStart rise), counts
// pulses, and compares DacValue at every ConfigLoad against the queue of
// codes the stimulus expects.
// ---------------------------------------------------------------------------
module tb_daq_sweep_scheduler;

    localparam int TIMEOUT_TB = 100;

    logic Clk = 1'b0;
    logic reset;

    always #5 Clk = ~Clk;

    daq_sweep_scheduler_if bus ();

    daq_sweep_scheduler #(
        .ARM_WAIT    (64),
        .TRIG_WIDTH  (4),
        .DROP_CYCLES (16),
        .TIMEOUT     (TIMEOUT_TB)
    ) dut (
        .Clk   (Clk),
        .reset (reset),
        .bus   (bus)
    );

    int         n_vec = 0;
    int         n_err = 0;
    logic [9:0] exp_q[$];
    int         acq_rises;
    int         cfg_pulses;
    int         resp_mode;      // 0: answer OnceEnd, otherwise silent
    bit         auto_cfg;
    logic       resp_once_end;
    logic       man_once_end;
    logic       resp_cfg_done;
    logic       man_cfg_done;

    assign bus.OnceEnd    = resp_once_end | man_once_end;
    assign bus.ConfigDone = resp_cfg_done | man_cfg_done;

    task automatic tick(input int n);
        repeat (n) @(posedge Clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        assert (got === exp) else begin
            n_err++;
            $error("FAIL %s: observed %0d expected %0d", tag, got, exp);
        end
    endtask

    task automatic check_all_zero(input string tag);
        check({tag, "_ms"},    32'(bus.ModuleStart),   0);
        check({tag, "_acq"},   32'(bus.AcqStart),      0);
        check({tag, "_cfg"},   32'(bus.ConfigLoad),    0);
        check({tag, "_busy"},  32'(bus.Busy),          0);
        check({tag, "_done"},  32'(bus.SweepDone),     0);
        check({tag, "_tout"},  32'(bus.TimeoutFlag),   0);
        check({tag, "_dac"},   32'(bus.DacValue),      0);
        check({tag, "_cnt"},   32'(bus.StepTrigCount), 0);
        check({tag, "_state"}, 32'(bus.dbg_state),     0);
    endtask

    task automatic start_sweep(input logic [9:0] s, input logic [9:0] e, input logic [9:0] st,
                               input logic [15:0] tps, input logic [15:0] per);
        bus.StartDac        = s;
        bus.EndDac          = e;
        bus.DacStep         = st;
        bus.TriggersPerStep = tps;
        bus.TriggerPeriod   = per;
        acq_rises           = 0;
        cfg_pulses          = 0;
        bus.SweepStart      = 1'b1;
    endtask

    task automatic wait_done(input string tag, input int budget);
        int k;
        for (k = 0; k < budget; k++) begin
            if (bus.SweepDone) break;
            tick(1);
        end
        check(tag, 32'(k < budget), 1);
    endtask

    task automatic wait_cfgload(input string tag, input int budget);
        int k;
        for (k = 0; k < budget; k++) begin
            if (bus.ConfigLoad) break;
            tick(1);
        end
        check(tag, 32'(k < budget), 1);
    endtask

    // Returns #1 after the edge at which AcqStart was first seen low again.
    task automatic wait_acq_fall(input string tag, input int budget);
        int k;
        bit seen;
        seen = 1'b0;
        for (k = 0; k < budget; k++) begin
            if (bus.AcqStart) seen = 1'b1;
            else if (seen) break;
            tick(1);
        end
        check(tag, 32'(k < budget), 1);
    endtask

    task automatic end_sweep();
        bus.SweepStart = 1'b0;
        tick(2);
    endtask

    // Loader / slave-DAQ models and the DacValue scoreboard.
    initial begin : responder
        int   once_cd;
        int   once_hold;
        int   cfg_cd;
        logic acq_prev;
        once_cd       = 0;
        once_hold     = 0;
        cfg_cd        = 0;
        acq_prev      = 1'b0;
        resp_once_end = 1'b0;
        resp_cfg_done = 1'b0;
        forever begin
            @(posedge Clk);
            #1;
            if (bus.AcqStart && !acq_prev) begin
                acq_rises++;
                if (resp_mode == 0) once_cd = 20;
            end
            acq_prev = bus.AcqStart;
            if (bus.ConfigLoad) begin
                cfg_pulses++;
                n_vec++;
                assert (exp_q.size() != 0) else begin
                    n_err++;
                    $error("FAIL dac_seq: observed ConfigLoad with DacValue %0d, expected no reload", bus.DacValue);
                end
                if (exp_q.size() != 0) check("dac_seq", 32'(bus.DacValue), 32'(exp_q.pop_front()));
                if (auto_cfg) cfg_cd = 3;
            end
            resp_cfg_done = 1'b0;
            if (cfg_cd > 0) begin
                cfg_cd--;
                if (cfg_cd == 0) resp_cfg_done = 1'b1;
            end
            resp_once_end = (once_hold > 0);
            if (once_hold > 0) once_hold--;
            if (once_cd > 0) begin
                once_cd--;
                if (once_cd == 0) once_hold = 3;
            end
        end
    end

    initial begin : stimulus
        reset               = 1'b1;
        bus.SweepStart      = 1'b0;
        bus.StartDac        = '0;
        bus.EndDac          = '0;
        bus.DacStep         = '0;
        bus.TriggersPerStep = '0;
        bus.TriggerPeriod   = '0;
        man_once_end        = 1'b0;
        man_cfg_done        = 1'b0;
        resp_mode           = 1;
        auto_cfg            = 1'b1;
        acq_rises           = 0;
        cfg_pulses          = 0;
        tick(3);
        check_all_zero("reset");
        reset = 1'b0;
        tick(2);

        // 1: basic sweep 100..104 step 2, 3 triggers per code.
        resp_mode = 0;
        exp_q.push_back(10'd100);
        exp_q.push_back(10'd102);
        exp_q.push_back(10'd104);
        start_sweep(10'd100, 10'd104, 10'd2, 16'd3, 16'd8);
        tick(1);
        check("t1_load_state", 32'(bus.dbg_state), 1);
        check("t1_busy", 32'(bus.Busy), 1);
        check("t1_cfgload_pre", 32'(bus.ConfigLoad), 0);
        tick(1);
        check("t1_cfgload_pulse", 32'(bus.ConfigLoad), 1);
        tick(1);
        check("t1_cfgload_end", 32'(bus.ConfigLoad), 0);
        wait_done("t1_done_wait", 3000);
        check("t1_done", 32'(bus.SweepDone), 1);
        check("t1_dac_final", 32'(bus.DacValue), 104);
        check("t1_stepcnt", 32'(bus.StepTrigCount), 3);
        check("t1_tout", 32'(bus.TimeoutFlag), 0);
        check("t1_acq_pulses", 32'(acq_rises), 9);
        check("t1_cfg_pulses", 32'(cfg_pulses), 3);
        check("t1_queue_empty", 32'(exp_q.size()), 0);
        check("t1_ms_done", 32'(bus.ModuleStart), 0);
        end_sweep();
        check("t1_idle_busy", 32'(bus.Busy), 0);
        check("t1_idle_done", 32'(bus.SweepDone), 0);
        check("t1_idle_state", 32'(bus.dbg_state), 0);

        // 2: step 0 and 0 triggers behave as 1; arm/trigger timing with a
        // manually driven ConfigDone and a stray ConfigDone during ARM.
        auto_cfg = 1'b0;
        exp_q.push_back(10'd5);
        start_sweep(10'd5, 10'd5, 10'd0, 16'd0, 16'd8);
        wait_cfgload("t2_cfg_wait", 20);
        tick(2);
        man_cfg_done = 1'b1;
        tick(1);                                   // edge M sampled ConfigDone
        man_cfg_done = 1'b0;
        check("t2_ms_before", 32'(bus.ModuleStart), 0);
        tick(1);                                   // M+1
        check("t2_ms_rise", 32'(bus.ModuleStart), 1);
        tick(8);
        man_cfg_done = 1'b1;                       // ignored in ARM
        tick(1);                                   // M+10
        man_cfg_done = 1'b0;
        tick(54);                                  // M+64
        check("t2_acq_pre", 32'(bus.AcqStart), 0);
        tick(1);                                   // M+65
        check("t2_acq_rise", 32'(bus.AcqStart), 1);
        tick(3);                                   // M+68
        check("t2_acq_last", 32'(bus.AcqStart), 1);
        tick(1);                                   // M+69
        check("t2_acq_fall", 32'(bus.AcqStart), 0);
        check("t2_wait_end", 32'(bus.dbg_state), 5);
        wait_done("t2_done_wait", 500);
        check("t2_acq_pulses", 32'(acq_rises), 1);
        check("t2_cfg_pulses", 32'(cfg_pulses), 1);
        check("t2_stepcnt", 32'(bus.StepTrigCount), 1);
        check("t2_dac", 32'(bus.DacValue), 5);
        auto_cfg = 1'b1;
        end_sweep();

        // 3: next code would exceed 1023; no wrap.
        exp_q.push_back(10'd1020);
        start_sweep(10'd1020, 10'd1023, 10'd8, 16'd1, 16'd8);
        wait_done("t3_done_wait", 1000);
        check("t3_dac", 32'(bus.DacValue), 1020);
        check("t3_cfg_pulses", 32'(cfg_pulses), 1);
        check("t3_acq_pulses", 32'(acq_rises), 1);
        check("t3_tout", 32'(bus.TimeoutFlag), 0);
        end_sweep();

        // 4: slave never answers; every trigger times out.
        resp_mode = 1;
        exp_q.push_back(10'd10);
        exp_q.push_back(10'd11);
        exp_q.push_back(10'd12);
        start_sweep(10'd10, 10'd12, 10'd1, 16'd2, 16'd8);
        wait_done("t4_done_wait", 3000);
        check("t4_tout", 32'(bus.TimeoutFlag), 1);
        check("t4_stepcnt", 32'(bus.StepTrigCount), 2);
        check("t4_acq_pulses", 32'(acq_rises), 6);
        check("t4_cfg_pulses", 32'(cfg_pulses), 3);
        check("t4_dac", 32'(bus.DacValue), 12);
        end_sweep();
        check("t4_tout_sticky", 32'(bus.TimeoutFlag), 1);

        // 5: abort in WAIT_END of the second trigger, then restart.
        exp_q.push_back(10'd200);
        start_sweep(10'd200, 10'd210, 10'd5, 16'd2, 16'd8);
        tick(1);
        check("t5_tout_cleared", 32'(bus.TimeoutFlag), 0);
        wait_acq_fall("t5_fall1", 400);
        wait_acq_fall("t5_fall2", 400);
        tick(3);
        check("t5_ms_before_abort", 32'(bus.ModuleStart), 1);
        bus.SweepStart = 1'b0;
        tick(1);
        check("t5_abort_ms", 32'(bus.ModuleStart), 0);
        check("t5_abort_acq", 32'(bus.AcqStart), 0);
        check("t5_abort_busy", 32'(bus.Busy), 0);
        check("t5_abort_state", 32'(bus.dbg_state), 0);
        check("t5_abort_dac", 32'(bus.DacValue), 200);
        check("t5_abort_cnt", 32'(bus.StepTrigCount), 1);
        check("t5_abort_tout", 32'(bus.TimeoutFlag), 1);
        tick(2);
        resp_mode = 0;
        exp_q.push_back(10'd200);
        exp_q.push_back(10'd205);
        exp_q.push_back(10'd210);
        start_sweep(10'd200, 10'd210, 10'd5, 16'd2, 16'd8);
        tick(1);
        check("t5_restart_tout", 32'(bus.TimeoutFlag), 0);
        check("t5_restart_dac", 32'(bus.DacValue), 200);
        check("t5_restart_cnt", 32'(bus.StepTrigCount), 0);
        wait_done("t5_done_wait", 3000);
        check("t5_tout_final", 32'(bus.TimeoutFlag), 0);
        check("t5_cfg_pulses", 32'(cfg_pulses), 3);
        check("t5_acq_pulses", 32'(acq_rises), 6);
        check("t5_dac_final", 32'(bus.DacValue), 210);
        end_sweep();

        // 6: OnceEnd edge coincident with timeout, then one cycle late,
        // then reset while in GAP.
        resp_mode = 2;
        exp_q.push_back(10'd50);
        start_sweep(10'd50, 10'd50, 10'd1, 16'd2, 16'd8);
        wait_acq_fall("t6_fall1", 400);            // edge F; WAIT_END since F-1
        tick(97);
        man_once_end = 1'b1;                       // sampled at F+98... edge at F+99
        tick(2);
        check("t6_coincident_tout", 32'(bus.TimeoutFlag), 0);
        check("t6_coincident_cnt", 32'(bus.StepTrigCount), 1);
        check("t6_gap_state", 32'(bus.dbg_state), 6);
        man_once_end = 1'b0;
        tick(8);
        check("t6_gap_acq_pre", 32'(bus.AcqStart), 0);
        tick(1);
        check("t6_gap_acq_rise", 32'(bus.AcqStart), 1);
        wait_acq_fall("t6_fall2", 400);
        tick(98);
        man_once_end = 1'b1;                       // edge would land one cycle late
        tick(1);
        check("t6_late_tout", 32'(bus.TimeoutFlag), 1);
        check("t6_late_cnt", 32'(bus.StepTrigCount), 2);
        tick(2);
        check("t6_late_gap_state", 32'(bus.dbg_state), 6);
        check("t6_late_cnt_hold", 32'(bus.StepTrigCount), 2);
        reset = 1'b1;
        man_once_end = 1'b0;
        tick(1);
        check_all_zero("t6_reset");
        reset = 1'b0;
        bus.SweepStart = 1'b0;
        tick(2);
        check("t6_queue_empty", 32'(exp_q.size()), 0);
        check("t6_idle_state", 32'(bus.dbg_state), 0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
